tdm_demux4: RTL
===============

Name: tdm_demux4

Overview:
- Receiving end of the team's 4:1 time-division-multiplexed link: the transmitter puts four channel samples on one line in slot order 0,1,2,3, with a sync flag on slot 0.
- This block tracks the slot position, routes each incoming sample to its channel, and publishes a complete 4-channel frame.
- It also signals frame-valid, lock status, and sync errors.
- Sits between the serial link input and downstream parallel consumers.

Parameters:
- WIDTH, 1, bits per slot sample; one channel's width.
- SYNC_EVERY_FRAME, 1, 1: every slot-0 sample must carry sync, otherwise lock is lost; 0: sync is checked only when present.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  sample strobe; din/sync are valid only when en=1.
- din  input  WIDTH  serial-link sample for the current slot.
- sync  input  1  marks the din sample as slot 0; meaningful only with en=1.
- out  output  4*WIDTH  last complete frame; channel k = out[k*WIDTH +: WIDTH].
- frame_valid  output  1  one-cycle pulse when out is updated.
- slot  output  2  slot index the next en sample is written to.
- locked  output  1  1 while in LOCKED state.
- sync_err  output  1  one-cycle pulse on a sync violation.

Behaviour:
- Reset (rst_n=0, asynchronous): state=HUNT, out=0, frame_valid=0, slot=0, locked=0, sync_err=0, shadow registers=0.
  - Reset is effective immediately mid-frame and discards any partial frame.
- Registered outputs only; no combinational path from inputs to outputs.
- Cycles with en=0 change nothing except clearing the frame_valid/sync_err pulses.
- HUNT:
  - en=1, sync=0: sample ignored.
  - en=1, sync=1: shadow[0]<=din, slot<=1, go to LOCKED.
- LOCKED, en=1, sync consistent (sync=1 with slot=0, or sync=0 with slot≠0):
  - shadow[slot]<=din; slot<=slot+1, wrapping 3->0.
  - When slot=3: out<={din, shadow[2], shadow[1], shadow[0]} and frame_valid=1, both on that same clock edge. Latency: out/frame_valid visible the cycle after the slot-3 sample is strobed.
- LOCKED, en=1, sync=1, slot≠0 (early sync):
  - sync_err pulses for one cycle.
  - Partial frame discarded; out is not updated.
  - Sample taken as slot 0: shadow[0]<=din, slot<=1, remain LOCKED.
- LOCKED, en=1, sync=0, slot=0 (missing sync):
  - SYNC_EVERY_FRAME=1: sync_err pulses, go to HUNT, slot<=0, sample discarded.
  - SYNC_EVERY_FRAME=0: accepted as a normal slot-0 sample.
- Other outputs:
  - out holds its value between frames and across loss of lock; it changes only on frame completion or reset.
  - frame_valid and sync_err are never asserted in the same cycle; a sync violation never completes a frame.
  - locked=1 exactly when state=LOCKED, and is registered together with the state.
  - In HUNT, slot reads 0.
- Back-to-back: en=1 every cycle sustains one frame per 4 clocks, with no gap between the slot-3 sample of one frame and the slot-0 sample of the next.

Test Plan:
- Reset: assert rst_n=0 mid-frame (after slots 0,1) then release -> out=0, frame_valid=0, locked=0, slot=0; a following sync frame 1,1,0,1 yields out=4'b1011.
- Basic frame (WIDTH=1): en=1 each cycle, din=1,0,1,1 with sync on the first -> locked=1 after cycle 1; one cycle after slot 3, out=4'b1101 and frame_valid high for exactly 1 cycle.
- Gapped strobe: same frame with en=0 for 3 cycles between each sample -> identical out=4'b1101; frame_valid pulses once; slot holds during the gaps.
- Early sync: frame 1,0,1,1 completes; the next frame sends 0,1, then sync with din=1 at slot 2 -> sync_err pulse, out stays 4'b1101, slot=1; continuing 0,0,1 -> out=4'b1001.
- Missing sync (SYNC_EVERY_FRAME=1): after a good frame, slot-0 sample arrives without sync -> sync_err pulse, locked=0, out unchanged; the next 3 samples without sync are ignored (slot=0); a re-sync frame relocks.
- Streaming: 16 consecutive frames with random data and WIDTH=4, en=1 continuously -> frame_valid every 4th cycle; each out equals the transmitted quadruple, slot 0 in the low nibble.

Source files
------------

// File: rtl/tdm_demux4.sv
// Receive side of the 4:1 TDM link: tracks slot position from the sync flag,
// collects four channel samples into shadow registers and publishes whole frames.
module tdm_demux4 #(
    parameter int WIDTH            = 1,
    parameter bit SYNC_EVERY_FRAME = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [WIDTH-1:0]   din,
    input  logic               sync,
    output logic [4*WIDTH-1:0] out,
    output logic               frame_valid,
    output logic [1:0]         slot,
    output logic               locked,
    output logic               sync_err
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;

    // Slot 3 goes straight to out, so only slots 0..2 need holding.
    logic [2:0][WIDTH-1:0] shadow;
    logic [2:0][WIDTH-1:0] shadow_nxt;
    logic [4*WIDTH-1:0]   out_nxt;
    logic [1:0]           slot_nxt;
    logic                 frame_valid_nxt;
    logic                 sync_err_nxt;

    // Per-strobe decode shared by the next-state and output processes.
    logic                 start_frame;
    logic                 take_sample;
    logic                 drop_lock;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= HUNT;
            locked <= 1'b0;
        end else begin
            state  <= state_nxt;
            locked <= (state_nxt == LOCKED);
        end
    end

    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        take_sample = 1'b0;
        drop_lock   = 1'b0;
        if (en) begin
            case (state)
                HUNT: begin
                    if (sync) begin
                        start_frame = 1'b1;
                        state_nxt   = LOCKED;
                    end
                end
                LOCKED: begin
                    // A sync always restarts at slot 0, whether on time or early.
                    if (sync) begin
                        start_frame = 1'b1;
                    end else if (slot == 2'd0 && SYNC_EVERY_FRAME) begin
                        drop_lock = 1'b1;
                        state_nxt = HUNT;
                    end else begin
                        take_sample = 1'b1;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_comb begin
        shadow_nxt      = shadow;
        out_nxt         = out;
        slot_nxt        = slot;
        frame_valid_nxt = 1'b0;
        sync_err_nxt    = 1'b0;
        if (start_frame) begin
            shadow_nxt[0] = din;
            slot_nxt      = 2'd1;
            sync_err_nxt  = (state == LOCKED) && (slot != 2'd0);
        end else if (drop_lock) begin
            slot_nxt     = 2'd0;
            sync_err_nxt = 1'b1;
        end else if (take_sample) begin
            case (slot)
                2'd0: shadow_nxt[0] = din;
                2'd1: shadow_nxt[1] = din;
                2'd2: shadow_nxt[2] = din;
                default: begin
                    out_nxt         = {din, shadow[2], shadow[1], shadow[0]};
                    frame_valid_nxt = 1'b1;
                end
            endcase
            slot_nxt = slot + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow      <= '0;
            out         <= '0;
            slot        <= 2'd0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            shadow      <= shadow_nxt;
            out         <= out_nxt;
            slot        <= slot_nxt;
            frame_valid <= frame_valid_nxt;
            sync_err    <= sync_err_nxt;
        end
    end

endmodule
